// File: rtl/gpr_file_scoreboard.sv
// -----------------------------------------------------------------------------
// gpr_file_scoreboard
//
// General-purpose register file for the 5-stage pipeline, with a per-register
// busy scoreboard that raises the decode-stage stall on RAW and WAW hazards.
//
// Ports
//   clock         system clock, all state updates on the rising edge
//   reset         synchronous, active-low reset
//   wr_en/addr/data           writeback port
//   rd_a_addr/rd_a_data       ALU read port A (combinational, write-through)
//   rd_b_addr/rd_b_data       ALU read port B (combinational, write-through)
//   bus_rd_en/bus_rd_addr     bus read request
//   bus_data/bus_valid        registered bus value and driver enable
//   issue_en/dst/dst_en/src_a/src_b/use_b   decode-stage issue request
//   flush         clears the scoreboard and discards this cycle's issue
//   stall         issue blocked this cycle (combinational)
//   busy_vec      registered scoreboard bits, one per register
// -----------------------------------------------------------------------------
module gpr_file_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_a_addr,
  output logic [DATA_W-1:0]   rd_a_data,
  input  logic [ADDR_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0]   rd_b_data,
  input  logic                bus_rd_en,
  input  logic [ADDR_W-1:0]   bus_rd_addr,
  output logic [DATA_W-1:0]   bus_data,
  output logic                bus_valid,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dst,
  input  logic                issue_dst_en,
  input  logic [ADDR_W-1:0]   issue_src_a,
  input  logic [ADDR_W-1:0]   issue_src_b,
  input  logic                issue_use_b,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  // Elaboration-time sanity check on the geometry.
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0 || (1 << ADDR_W) != NUM_REGS) begin : g_bad_params
    $error("gpr_file_scoreboard: NUM_REGS must be a power of 2 >= 2 and equal 2**ADDR_W");
  end

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_onehot;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] busy_next;
  logic [DATA_W-1:0]   bus_rd_value;
  logic                hazard;
  logic                accept;

  // Write-through: a same-cycle writeback is visible on every read path.
  function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr);
    return (wr_en && wr_addr == addr) ? wr_data : regs[addr];
  endfunction

  assign rd_a_data    = bypass_read(rd_a_addr);
  assign rd_b_data    = bypass_read(rd_b_addr);
  assign bus_rd_value = bypass_read(bus_rd_addr);

  // A writeback landing this cycle resolves the hazard on its register.
  assign wr_onehot = wr_en ? (NUM_REGS'(1) << wr_addr) : '0;
  assign busy_eff  = busy_vec & ~wr_onehot;

  assign hazard = busy_eff[issue_src_a]
                | (issue_use_b  & busy_eff[issue_src_b])
                | (issue_dst_en & busy_eff[issue_dst]);

  // Reset holds off issue entirely, so stall is masked while reset is low.
  assign stall  = reset & issue_en & ~flush & hazard;
  assign accept = issue_en & ~flush & ~hazard;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    busy_next = busy_vec & ~wr_onehot;
    // Set after clear: a new writer claiming the register being written back
    // keeps it busy.
    if (accept && issue_dst_en) begin
      busy_next[issue_dst] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the register array is reset explicitly because software relies
      // on all registers reading zero after reset; this keeps it out of RAM
      // macros, which is acceptable at this size.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy_vec  <= '0;
      bus_data  <= '0;
      bus_valid <= 1'b0;
    end else begin
      // Writeback is performed even in a flush cycle.
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end
      busy_vec  <= busy_next;
      bus_valid <= bus_rd_en;
      bus_data  <= bus_rd_en ? bus_rd_value : '0;
    end
  end

endmodule

// File: tb/tb_gpr_file_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_gpr_file_scoreboard
//
// Directed self-checking bench for gpr_file_scoreboard. Two instances: the
// default 8x8 geometry and a 16x16 geometry. Inputs change 1 time unit after
// the rising edge; outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_gpr_file_scoreboard;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // 8x8 instance signals
  logic       wr_en, bus_rd_en, bus_valid, issue_en, issue_dst_en, issue_use_b, flush, stall;
  logic [2:0] wr_addr, rd_a_addr, rd_b_addr, bus_rd_addr, issue_dst, issue_src_a, issue_src_b;
  logic [7:0] wr_data, rd_a_data, rd_b_data, bus_data, busy_vec;

  // 16x16 instance signals
  logic        w_en16, bus_en16, bus_valid16, iss_en16, iss_dst_en16, iss_use_b16, flush16, stall16;
  logic [3:0]  w_addr16, ra16, rb16, bus_addr16, iss_dst16, iss_a16, iss_b16;
  logic [15:0] w_data16, rd_a16, rd_b16, bus_data16, busy16;

  int checks = 0;
  int errors = 0;

  gpr_file_scoreboard #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3)) u_dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .bus_rd_en(bus_rd_en), .bus_rd_addr(bus_rd_addr),
    .bus_data(bus_data), .bus_valid(bus_valid),
    .issue_en(issue_en), .issue_dst(issue_dst), .issue_dst_en(issue_dst_en),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_use_b(issue_use_b),
    .flush(flush), .stall(stall), .busy_vec(busy_vec)
  );

  gpr_file_scoreboard #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4)) u_dut16 (
    .clock(clock), .reset(reset),
    .wr_en(w_en16), .wr_addr(w_addr16), .wr_data(w_data16),
    .rd_a_addr(ra16), .rd_a_data(rd_a16),
    .rd_b_addr(rb16), .rd_b_data(rd_b16),
    .bus_rd_en(bus_en16), .bus_rd_addr(bus_addr16),
    .bus_data(bus_data16), .bus_valid(bus_valid16),
    .issue_en(iss_en16), .issue_dst(iss_dst16), .issue_dst_en(iss_dst_en16),
    .issue_src_a(iss_a16), .issue_src_b(iss_b16), .issue_use_b(iss_use_b16),
    .flush(flush16), .stall(stall16), .busy_vec(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: inputs may change right after, registered outputs are
  // stable from here to the next edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Present an issue request on the 8x8 instance.
  task automatic issue(input logic en, input logic dst_en, input logic [2:0] dst,
                       input logic [2:0] src_a, input logic use_b, input logic [2:0] src_b);
    issue_en     = en;
    issue_dst_en = dst_en;
    issue_dst    = dst;
    issue_src_a  = src_a;
    issue_use_b  = use_b;
    issue_src_b  = src_b;
  endtask

  initial begin
    // ---- 1. reset with a writeback pending: reset must win -------------------
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h55;
    rd_a_addr = 3'd3; rd_b_addr = 3'd0;
    bus_rd_en = 1'b0; bus_rd_addr = 3'd0; flush = 1'b0;
    issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    w_en16 = 1'b0; w_addr16 = '0; w_data16 = '0; ra16 = '0; rb16 = '0;
    bus_en16 = 1'b0; bus_addr16 = '0; flush16 = 1'b0;
    iss_en16 = 1'b0; iss_dst16 = '0; iss_dst_en16 = 1'b0; iss_a16 = '0; iss_b16 = '0; iss_use_b16 = 1'b0;
    step();
    step();
    reset = 1'b1;
    wr_en = 1'b0;
    settle();
    check("reset_rd_a_reg3", 32'(rd_a_data), 32'h00);
    check("reset_busy_vec", 32'(busy_vec), 32'h00);
    check("reset_bus_valid", 32'(bus_valid), 32'h0);
    check("reset_bus_data", 32'(bus_data), 32'h00);
    step();

    // ---- 2. write, bypass, bus port ------------------------------------------
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hA5;
    rd_a_addr = 3'd2; rd_b_addr = 3'd3;
    settle();
    check("bypass_rd_a", 32'(rd_a_data), 32'hA5);
    check("bypass_rd_b_other", 32'(rd_b_data), 32'h00);
    step();
    wr_en = 1'b0;
    rd_b_addr = 3'd2;
    settle();
    check("stored_rd_a", 32'(rd_a_data), 32'hA5);
    check("stored_rd_b_same_reg", 32'(rd_b_data), 32'hA5);
    bus_rd_en = 1'b1; bus_rd_addr = 3'd2;
    step();
    bus_rd_en = 1'b0;
    settle();
    check("bus_valid_set", 32'(bus_valid), 32'h1);
    check("bus_data_reg2", 32'(bus_data), 32'hA5);
    step();
    check("bus_valid_clear", 32'(bus_valid), 32'h0);
    check("bus_data_zero", 32'(bus_data), 32'h00);
    // bus read of a register being written this cycle takes the new value
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h6B;
    bus_rd_en = 1'b1; bus_rd_addr = 3'd6;
    step();
    wr_en = 1'b0; bus_rd_en = 1'b0;
    settle();
    check("bus_bypass_reg6", 32'(bus_data), 32'h6B);

    // ---- 3. RAW stall ---------------------------------------------------------
    step();
    issue(1'b1, 1'b1, 3'd4, 3'd0, 1'b0, 3'd0);
    settle();
    check("raw_issue_dst4_no_stall", 32'(stall), 32'h0);
    step();
    check("raw_busy_after_issue", 32'(busy_vec), 32'h10);
    issue(1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 3'd0);
    rd_a_addr = 3'd4;
    settle();
    check("raw_stall_cycle1", 32'(stall), 32'h1);
    step();
    check("raw_stall_cycle2", 32'(stall), 32'h1);
    check("raw_busy_held", 32'(busy_vec), 32'h10);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h3C;
    settle();
    check("raw_wb_releases_stall", 32'(stall), 32'h0);
    check("raw_wb_bypass", 32'(rd_a_data), 32'h3C);
    step();
    wr_en = 1'b0;
    issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    settle();
    check("raw_busy_cleared", 32'(busy_vec), 32'h00);

    // ---- 4. WAW and same-cycle set/clear -------------------------------------
    issue(1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0);
    step();
    check("waw_busy1_set", 32'(busy_vec), 32'h02);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h11;
    settle();
    check("waw_with_wb_no_stall", 32'(stall), 32'h0);
    step();
    wr_en = 1'b0;
    settle();
    check("waw_busy1_kept", 32'(busy_vec), 32'h02);
    check("waw_stall_no_wb", 32'(stall), 32'h1);
    step();
    check("waw_busy1_still", 32'(busy_vec), 32'h02);
    // source B hazard only counts when source B is used
    issue(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1);
    settle();
    check("src_b_used_stall", 32'(stall), 32'h1);
    issue_use_b = 1'b0;
    settle();
    check("src_b_unused_no_stall", 32'(stall), 32'h0);

    // ---- 5. flush -------------------------------------------------------------
    step();
    issue(1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0);
    step();
    issue(1'b1, 1'b1, 3'd7, 3'd0, 1'b0, 3'd0);
    step();
    issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    settle();
    check("flush_pre_busy", 32'(busy_vec), 32'h86);
    flush = 1'b1;
    issue(1'b1, 1'b1, 3'd5, 3'd1, 1'b0, 3'd0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h77;
    settle();
    check("flush_stall_low", 32'(stall), 32'h0);
    step();
    flush = 1'b0; wr_en = 1'b0;
    issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    rd_a_addr = 3'd0; rd_b_addr = 3'd1;
    settle();
    check("flush_busy_cleared", 32'(busy_vec), 32'h00);
    check("flush_wb_reg0", 32'(rd_a_data), 32'h77);
    check("flush_keeps_reg1", 32'(rd_b_data), 32'h11);
    issue(1'b1, 1'b1, 3'd5, 3'd5, 1'b0, 3'd0);
    settle();
    check("flush_reg5_free", 32'(stall), 32'h0);

    // ---- reset overrides a pending hazard ------------------------------------
    step();
    check("pre_reset_busy5", 32'(busy_vec), 32'h20);
    reset = 1'b0;
    issue(1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 3'd0);
    settle();
    check("reset_masks_stall", 32'(stall), 32'h0);
    step();
    reset = 1'b1;
    issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    settle();
    check("reset2_busy", 32'(busy_vec), 32'h00);
    check("reset2_reg1", 32'(rd_b_data), 32'h00);

    // ---- 6. 16x16 geometry ----------------------------------------------------
    step();
    w_en16 = 1'b1; w_addr16 = 4'd15; w_data16 = 16'hBEEF;
    ra16 = 4'd15; rb16 = 4'd15;
    settle();
    check("p16_bypass_a", 32'(rd_a16), 32'hBEEF);
    check("p16_bypass_b", 32'(rd_b16), 32'hBEEF);
    step();
    w_en16 = 1'b0;
    settle();
    check("p16_stored_a", 32'(rd_a16), 32'hBEEF);
    check("p16_stored_b", 32'(rd_b16), 32'hBEEF);
    iss_en16 = 1'b1; iss_dst_en16 = 1'b1; iss_dst16 = 4'd15;
    step();
    check("p16_busy15_set", 32'(busy16), 32'h8000);
    iss_dst_en16 = 1'b0; iss_a16 = 4'd15;
    settle();
    check("p16_raw_stall", 32'(stall16), 32'h1);
    w_en16 = 1'b1; w_data16 = 16'h1234;
    settle();
    check("p16_wb_no_stall", 32'(stall16), 32'h0);
    bus_en16 = 1'b1; bus_addr16 = 4'd15;
    step();
    w_en16 = 1'b0; iss_en16 = 1'b0; bus_en16 = 1'b0;
    settle();
    check("p16_busy15_cleared", 32'(busy16), 32'h0000);
    check("p16_bus_data", 32'(bus_data16), 32'h1234);
    check("p16_bus_valid", 32'(bus_valid16), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
